uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter for the user project: accepts bytes on a valid/ready write port, queues them in a small FIFO and serialises them onto a single TX line.
- Drives the user-project UART pad (mprj_io[6]) that the testbench UART monitor decodes, so firmware and user logic can print status without the management SoC UART.
- One clock domain; no receive path.

Parameters:
- CLKS_PER_BIT, 4167, clocks per bit period (40 MHz / 9600 baud); must be >= 2.
- FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- resetb  in  1  asynchronous, active-low reset.
- enable  in  1  1 = may start new frames; 0 = finish current frame, then hold idle.
- wr_valid  in  1  write request.
- wr_data  in  8  byte to send.
- wr_ready  out  1  FIFO not full.
- tx  out  1  serial output; idle high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Reset (resetb low, async): tx=1, busy=0, wr_ready=1, fifo_level=0, FSM=IDLE, bit/baud counters=0, FIFO pointers=0. Release takes effect on the next posedge.
- Write: a byte is pushed on a posedge where wr_valid && wr_ready. wr_ready = !full, registered-state only; no combinational path from any input.
- Full: wr_ready=0 even if a pop occurs in the same cycle. wr_valid while full is ignored; no data is corrupted.
- Simultaneous push and pop when not full: fifo_level is unchanged and both operations complete.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START when enable && FIFO non-empty. The head byte is popped into the shift register on that edge and tx goes 0 on that edge.
- START: tx=0 for exactly CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit counter -> STOP after bit 7.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
  - if enable && non-empty: pop and go directly to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: a byte written into an empty FIFO while IDLE && enable is visible at the head on edge N+1; tx falls on edge N+2.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).
- enable deasserted mid-frame: the current frame completes unaltered. No new pop until enable=1.
- busy = (FSM != IDLE) || (fifo_level != 0).
- Reset mid-frame: tx returns to 1 immediately. Queued bytes are discarded.

Decomposition:
- uart_pkg contains:
  - state enum tx_state_t {IDLE, START, DATA, STOP};
  - constants DATA_BITS=8, STOP_BITS=1, IDLE_LEVEL=1'b1.
- One sub-module: sync_fifo. Parameterised width and depth, registered full/empty, level output, same clock and resetb.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Single byte 0xA5 written while idle -> tx low 2 edges after accept. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 (start, LSB-first data), stop=1. Frame is 40 cycles; busy falls on the cycle after the stop bit ends.
- Burst 0x48,0x69,0x0A written on consecutive cycles -> three frames back-to-back, 120 cycles total, no idle cycle between stop and start. fifo_level peaks at 2 (head already popped).
- Write 17 bytes with enable=0 -> wr_ready drops after the 16th. The 17th write is ignored and fifo_level=16. Set enable=1 -> 16 frames, data in order, fifo_level reaches 0.
- enable dropped 5 cycles into a frame of 0xFF with 2 bytes queued -> that frame completes (40 cycles), then tx stays 1 and fifo_level stays 2 until enable returns.
- resetb pulsed low mid-DATA -> tx=1 and fifo_level=0 asynchronously. After release, a new write of 0x33 transmits correctly.
- CLKS_PER_BIT=4167 with the testbench UART decoder: firmware-style string "OK\n" is received and printed correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and framing constants for the buffered UART TX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Byte write port (valid/ready) into the UART transmit queue.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered full/empty flags and level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                       clock,
    input  wire logic                       resetb,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_pop_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] c_FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Flags come from the next level so they never lag the pointers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_next;
            r_full  <= (w_level_next == c_FULL_LEVEL);
            r_empty <= (w_level_next == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_level    = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered 8N1 UART transmitter: byte queue plus serialiser FSM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic                          clock,
    input  wire logic                          resetb,
    input  wire logic                          enable,
    uart_tx_fifo_if.slave                      wr,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] c_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    c_BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [BW-1:0]        r_baud;
    logic [BW-1:0]        w_baud_next;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_head_valid;
    logic                 w_pop;
    logic                 w_can_pop;
    logic                 w_baud_done;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_head;
    logic [LW-1:0]        w_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetb      (resetb),
        .i_push      (wr.wr_valid),
        .i_push_data (wr.wr_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_level)
    );

    // The head entry is only trusted a cycle after the queue became non-empty.
    assign w_can_pop   = enable && r_head_valid && !w_fifo_empty;
    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
                w_tx_next   = IDLE_LEVEL;
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_tx_next    = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    w_bit_next  = r_bit + 1'b1;
                    if (r_bit == c_BIT_LAST) begin
                        w_tx_next    = IDLE_LEVEL;
                        w_state_next = STOP;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (w_can_pop) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_tx_next    = 1'b0;
                        w_state_next = START;
                    end else begin
                        w_tx_next    = IDLE_LEVEL;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_tx         <= IDLE_LEVEL;
            r_head_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_baud       <= w_baud_next;
            r_bit        <= w_bit_next;
            r_shift      <= w_shift_next;
            r_tx         <= w_tx_next;
            r_head_valid <= !w_fifo_empty;
        end
    end

    assign wr.wr_ready = !w_fifo_full;
    assign tx          = r_tx;
    assign busy        = (r_state != IDLE) || (w_level != '0);
    assign fifo_level  = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed table-driven bench for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // bits[i] is the line level during bit period i
    } vec_t;

    logic          clock = 1'b0;
    logic          resetb;
    logic          enable;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;

    uart_tx_fifo_if wr_if ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .wr         (wr_if),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    vec_t       vecs [16];
    logic [9:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         lvl_max  = 0;
    string      msg      = "OK\n";

    task automatic check(input string name, input bit ok, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        check(name, got === exp, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] bits_of(input logic [7:0] d);
        for (int i = 0; i < 16; i++)
            if (vecs[i].data == d) return vecs[i].bits;
        return 10'h000;
    endfunction

    // Current time must be the first sample of the first start bit.
    task automatic check_stream(input string name, input int drop_at);
        int         n;
        int         cerr;
        logic [9:0] obs;
        n = exp_q.size();
        for (int f = 0; f < n; f++) begin
            obs  = '0;
            cerr = 0;
            for (int c = 0; c < 40; c++) begin
                if (f != 0 || c != 0) cyc();
                if (f * 40 + c == drop_at) enable = 1'b0;
                if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
                if (tx !== exp_q[f][c / 4]) cerr++;
                if (c % 4 == 2) obs[c / 4] = tx;
            end
            check($sformatf("%s frame %0d (errcycles<<10|bits)", name, f),
                  (obs === exp_q[f]) && (cerr == 0), {22'(cerr), obs}, {22'd0, exp_q[f]});
        end
        exp_q.delete();
    endtask

    task automatic send_one(input logic [7:0] d, input logic [9:0] bits, input string name);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        cyc();
        wr_if.wr_valid = 1'b0;
        check_eq({name, " level after write"}, fifo_level, 1);
        cyc();
        check_eq({name, " tx before start"}, tx, 1);
        cyc();
        exp_q.push_back(bits);
        check_stream(name, -1);
        check_eq({name, " busy in stop"}, busy, 1);
        cyc();
        check_eq({name, " busy after frame"}, busy, 0);
        check_eq({name, " tx idle after frame"}, tx, 1);
    endtask

    task automatic decode_byte(output logic [7:0] d, output bit ok);
        int   w;
        logic st;
        logic sp;
        w = 0;
        d = '0;
        while (tx !== 1'b0 && w < 200) begin
            cyc();
            w++;
        end
        ok = (tx === 1'b0);
        if (!ok) return;
        repeat (2) cyc();
        st = tx;
        for (int b = 0; b < 8; b++) begin
            repeat (4) cyc();
            d[b] = tx;
        end
        repeat (4) cyc();
        sp = tx;
        ok = (st === 1'b0) && (sp === 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] got;
        bit         ok;
        int         bad;

        vecs[0]  = '{8'hA5, 10'b1_10100101_0};
        vecs[1]  = '{8'h00, 10'b1_00000000_0};
        vecs[2]  = '{8'hFF, 10'b1_11111111_0};
        vecs[3]  = '{8'h48, 10'b1_01001000_0};
        vecs[4]  = '{8'h69, 10'b1_01101001_0};
        vecs[5]  = '{8'h0A, 10'b1_00001010_0};
        vecs[6]  = '{8'h33, 10'b1_00110011_0};
        vecs[7]  = '{8'h01, 10'b1_00000001_0};
        vecs[8]  = '{8'h80, 10'b1_10000000_0};
        vecs[9]  = '{8'h4F, 10'b1_01001111_0};
        vecs[10] = '{8'h4B, 10'b1_01001011_0};
        vecs[11] = '{8'h5A, 10'b1_01011010_0};
        vecs[12] = '{8'hC3, 10'b1_11000011_0};
        vecs[13] = '{8'h3C, 10'b1_00111100_0};
        vecs[14] = '{8'h7E, 10'b1_01111110_0};
        vecs[15] = '{8'h96, 10'b1_10010110_0};

        resetb         = 1'b0;
        enable         = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        repeat (3) cyc();
        check_eq("reset tx", tx, 1);
        check_eq("reset busy", busy, 0);
        check_eq("reset wr_ready", wr_if.wr_ready, 1);
        check_eq("reset level", fifo_level, 0);
        resetb = 1'b1;
        cyc();
        enable = 1'b1;

        // single frames, one per table entry
        for (int i = 0; i < 16; i++)
            send_one(vecs[i].data, vecs[i].bits, $sformatf("vec%0d", i));

        // burst of three, frames must abut
        lvl_max        = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h48;
        cyc();
        lvl_max = int'(fifo_level);
        wr_if.wr_data = 8'h69;
        cyc();
        if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
        wr_if.wr_data = 8'h0A;
        cyc();
        wr_if.wr_valid = 1'b0;
        exp_q.push_back(10'b1_01001000_0);
        exp_q.push_back(10'b1_01101001_0);
        exp_q.push_back(10'b1_00001010_0);
        check_stream("burst", -1);
        check_eq("burst level peak", lvl_max, 2);
        cyc();
        check_eq("burst busy after", busy, 0);

        // fill to full with transmission held off
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = (i < 16) ? vecs[i].data : 8'hEE;
            cyc();
            if (i == 14) check_eq("wr_ready after 15 writes", wr_if.wr_ready, 1);
            if (i == 15) check_eq("wr_ready after 16 writes", wr_if.wr_ready, 0);
        end
        wr_if.wr_valid = 1'b0;
        check_eq("full level", fifo_level, 16);
        check_eq("full wr_ready", wr_if.wr_ready, 0);
        check_eq("held tx idle", tx, 1);
        check_eq("held busy", busy, 1);
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) exp_q.push_back(vecs[i].bits);
        check_stream("drain", -1);
        cyc();
        check_eq("drain level", fifo_level, 0);
        check_eq("drain busy", busy, 0);
        check_eq("drain wr_ready", wr_if.wr_ready, 1);

        // enable dropped five cycles into a frame
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'hFF;
        cyc();
        wr_if.wr_data = 8'h00;
        cyc();
        wr_if.wr_data = 8'hA5;
        cyc();
        wr_if.wr_valid = 1'b0;
        exp_q.push_back(10'b1_11111111_0);
        check_stream("drop", 5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tx !== 1'b1 || fifo_level !== 5'd2 || busy !== 1'b1) bad++;
        end
        check_eq("paused idle cycles with bad state", bad, 0);
        enable = 1'b1;
        cyc();
        exp_q.push_back(10'b1_00000000_0);
        exp_q.push_back(10'b1_10100101_0);
        check_stream("resume", -1);
        cyc();
        check_eq("resume level", fifo_level, 0);

        // asynchronous reset in the middle of the data bits
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h5A;
        cyc();
        wr_if.wr_data = 8'hC3;
        cyc();
        wr_if.wr_data = 8'h3C;
        cyc();
        wr_if.wr_valid = 1'b0;
        repeat (13) cyc();
        check_eq("pre-reset data bit", tx, 0);
        #2 resetb = 1'b0;
        #1;
        check_eq("async reset tx", tx, 1);
        check_eq("async reset level", fifo_level, 0);
        check_eq("async reset busy", busy, 0);
        check_eq("async reset wr_ready", wr_if.wr_ready, 1);
        cyc();
        #2 resetb = 1'b1;
        cyc();
        check_eq("post-release tx", tx, 1);
        send_one(8'h33, bits_of(8'h33), "post-reset");

        // receiver-style decode of a short message
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = msg[i];
            cyc();
        end
        wr_if.wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            decode_byte(got, ok);
            check($sformatf("rx char %0d", i), ok && (got === msg[i]), {23'd0, !ok, got}, {24'd0, msg[i]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
